// File: rtl/seq_multiplier16.sv
// Sequential 16x16 unsigned shift-add multiplier: one multiplier bit per clock,
// low half of the product presented with a one-cycle load strobe.
module seq_multiplier16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        load,
  output logic [15:0] product,
  output logic        overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic [31:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {16'h0000, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          // 16th RUN edge: counter is about to reach 16
          if (cnt == 5'd15) begin
            product  <= acc_next[15:0];
            overflow <= |acc_next[31:16];
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);
  assign load = done;

endmodule
